// File: rtl/smartcount_people_counter.sv
// Doorway occupancy counter: two beam sensors are synchronised, debounced and
// decoded into entry/exit events that drive a saturating 7-bit count.
module smartcount_people_counter #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES  = 100000000,
  parameter int MAX_COUNT       = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_a,
  input  logic       sensor_b,
  output logic [6:0] count_o,
  output logic       ready_o,
  output logic       update_o,
  output logic       dir_o,
  output logic       busy_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, WAIT_CLR
  } state_t;

  logic [1:0] raw;
  logic [1:0] filt;
  assign raw = {sensor_b, sensor_a};

  // Bit 0 is sensor a, bit 1 is sensor b; each path is identical.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_db
      logic            sync1_reg;
      logic            sync2_reg;
      logic            filt_reg;
      logic [DB_W-1:0] run_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          filt_reg  <= 1'b0;
          run_reg   <= '0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == filt_reg) begin
            run_reg <= '0;
          end else if (run_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            filt_reg <= sync2_reg;
            run_reg  <= '0;
          end else begin
            run_reg <= run_reg + 1'b1;
          end
        end
      end

      assign filt[gi] = filt_reg;
    end
  endgenerate

  state_t          state_reg, state_next;
  logic [TO_W-1:0] timer_reg;
  logic [6:0]      count_reg;
  logic            ready_reg, update_reg, dir_reg;
  logic            entry_ev, exit_ev, in_seq;
  logic            a, b;

  assign a = filt[0];
  assign b = filt[1];
  assign in_seq = (state_reg != IDLE) && (state_reg != WAIT_CLR);

  always_comb begin
    state_next = state_reg;
    entry_ev   = 1'b0;
    exit_ev    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (a && !b)      state_next = IN1;
        else if (!a && b) state_next = OUT1;
        else if (a && b)  state_next = WAIT_CLR;
      end
      IN1: begin
        if (a && b)        state_next = IN2;
        else if (!a && !b) state_next = IDLE;
      end
      IN2: begin
        if (!a && b)       state_next = IN3;
        else if (a && !b)  state_next = IN1;
        else if (!a && !b) state_next = IDLE;
      end
      IN3: begin
        if (!a && !b) begin
          state_next = IDLE;
          entry_ev   = 1'b1;
        end else if (a && b) begin
          state_next = IN2;
        end
      end
      OUT1: begin
        if (a && b)        state_next = OUT2;
        else if (!a && !b) state_next = IDLE;
      end
      OUT2: begin
        if (a && !b)       state_next = OUT3;
        else if (!a && b)  state_next = OUT1;
        else if (!a && !b) state_next = IDLE;
      end
      OUT3: begin
        if (!a && !b) begin
          state_next = IDLE;
          exit_ev    = 1'b1;
        end else if (a && b) begin
          state_next = OUT2;
        end
      end
      WAIT_CLR: begin
        if (!a && !b) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A sequence parked too long in one step is abandoned without an event.
    if (in_seq && (state_next == state_reg) &&
        (timer_reg == TO_W'(TIMEOUT_CYCLES - 1))) begin
      state_next = WAIT_CLR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      timer_reg  <= '0;
      count_reg  <= '0;
      ready_reg  <= 1'b0;
      update_reg <= 1'b0;
      dir_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ready_reg  <= 1'b1;
      update_reg <= 1'b0;
      if (!in_seq || (state_next != state_reg)) timer_reg <= '0;
      else                                      timer_reg <= timer_reg + 1'b1;
      if (entry_ev) begin
        dir_reg <= 1'b1;
        if (count_reg < 7'(MAX_COUNT)) begin
          count_reg  <= count_reg + 7'd1;
          update_reg <= 1'b1;
        end
      end else if (exit_ev) begin
        dir_reg <= 1'b0;
        if (count_reg != 7'd0) begin
          count_reg  <= count_reg - 7'd1;
          update_reg <= 1'b1;
        end
      end
    end
  end

  assign count_o  = count_reg;
  assign ready_o  = ready_reg;
  assign update_o = update_reg;
  assign dir_o    = dir_reg;
  assign busy_o   = (state_reg != IDLE);

endmodule

// File: tb/tb_smartcount_people_counter.sv
// Bench for the doorway counter: gesture table, randomized gestures against a
// count-level model, and hand-written debounce/saturation/timeout/reset cases.
module tb_smartcount_people_counter;

  localparam int DB  = 4;
  localparam int TO  = 200;
  localparam int MAX = 99;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sensor_a = 1'b0;
  logic       sensor_b = 1'b0;
  logic [6:0] count_o;
  logic       ready_o, update_o, dir_o, busy_o;

  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;
  int busy_cnt = 0;
  int mc = 0;
  int md = 0;

  smartcount_people_counter #(
    .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO), .MAX_COUNT(MAX)
  ) dut (
    .clk(clk), .reset(reset), .sensor_a(sensor_a), .sensor_b(sensor_b),
    .count_o(count_o), .ready_o(ready_o), .update_o(update_o),
    .dir_o(dir_o), .busy_o(busy_o)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (update_o) pulse_cnt <= pulse_cnt + 1;
    if (busy_o)   busy_cnt  <= busy_cnt + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int         g;
    logic [6:0] cnt;
    logic       dir;
    int         pulses;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic ph(input logic a, input logic b, input int n);
    @(negedge clk);
    sensor_a = a;
    sensor_b = b;
    repeat (n - 1) @(negedge clk);
  endtask

  // Gestures: 0 entry, 1 exit, 2 abort at A, 3 backtracked entry,
  // 4 both beams at once, 5 entry abandoned at A&B, 6 abort at B.
  task automatic gesture(input int g, input int len);
    case (g)
      0: begin ph(1, 0, len); ph(1, 1, len); ph(0, 1, len); end
      1: begin ph(0, 1, len); ph(1, 1, len); ph(1, 0, len); end
      2: ph(1, 0, len);
      3: begin
        ph(1, 0, len); ph(1, 1, len); ph(1, 0, len);
        ph(1, 1, len); ph(0, 1, len);
      end
      4: ph(1, 1, len);
      5: begin ph(1, 0, len); ph(1, 1, len); end
      default: ph(0, 1, len);
    endcase
    ph(0, 0, len + 8);
  endtask

  function automatic int model_count(input int c, input int g);
    if (g == 0 || g == 3) return (c + 1 > MAX) ? MAX : c + 1;
    if (g == 1)           return (c - 1 < 0) ? 0 : c - 1;
    return c;
  endfunction

  function automatic int model_dir(input int d, input int g);
    if (g == 0 || g == 3) return 1;
    if (g == 1)           return 0;
    return d;
  endfunction

  task automatic run_check(input string tag, input int g, input int len,
                           input int ec, input int ed, input int ep);
    int p0;
    p0 = pulse_cnt;
    gesture(g, len);
    check({tag, " count"}, int'(count_o), ec);
    check({tag, " dir"}, int'(dir_o), ed);
    check({tag, " pulses"}, pulse_cnt - p0, ep);
    check({tag, " busy"}, int'(busy_o), 0);
  endtask

  initial begin
    int p0, b0, g, len, nc, nd;

    tbl[0]  = '{0, 7'd1, 1'b1, 1};
    tbl[1]  = '{0, 7'd2, 1'b1, 1};
    tbl[2]  = '{0, 7'd3, 1'b1, 1};
    tbl[3]  = '{0, 7'd4, 1'b1, 1};
    tbl[4]  = '{1, 7'd3, 1'b0, 1};
    tbl[5]  = '{1, 7'd2, 1'b0, 1};
    tbl[6]  = '{1, 7'd1, 1'b0, 1};
    tbl[7]  = '{1, 7'd0, 1'b0, 1};
    tbl[8]  = '{1, 7'd0, 1'b0, 0};
    tbl[9]  = '{2, 7'd0, 1'b0, 0};
    tbl[10] = '{3, 7'd1, 1'b1, 1};
    tbl[11] = '{4, 7'd1, 1'b1, 0};
    tbl[12] = '{5, 7'd1, 1'b1, 0};
    tbl[13] = '{6, 7'd1, 1'b1, 0};

    // Reset state and release
    repeat (5) @(negedge clk);
    check("rst count", int'(count_o), 0);
    check("rst ready", int'(ready_o), 0);
    check("rst update", int'(update_o), 0);
    check("rst busy", int'(busy_o), 0);
    check("rst dir", int'(dir_o), 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready after release", int'(ready_o), 1);

    for (int i = 0; i < 14; i++) begin
      run_check($sformatf("tbl%0d g%0d", i, tbl[i].g), tbl[i].g, 20,
                int'(tbl[i].cnt), int'(tbl[i].dir), tbl[i].pulses);
    end
    mc = int'(tbl[13].cnt);
    md = int'(tbl[13].dir);

    // Randomized gestures against the count model
    for (int i = 0; i < 25; i++) begin
      g   = int'($urandom_range(0, 6));
      len = int'($urandom_range(8, 30));
      nc  = model_count(mc, g);
      nd  = model_dir(md, g);
      run_check($sformatf("rnd%0d g%0d", i, g), g, len, nc, nd,
                (nc != mc) ? 1 : 0);
      mc = nc;
      md = nd;
    end

    // Short glitches on A never reach the filtered level
    b0 = busy_cnt;
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      ph(1, 0, 3);
      ph(0, 0, 3);
    end
    ph(0, 0, 10);
    check("glitch busy cycles", busy_cnt - b0, 0);
    check("glitch pulses", pulse_cnt - p0, 0);

    // Saturation at the ceiling
    while (mc < MAX) begin
      gesture(0, 8);
      mc++;
    end
    check("preload count", int'(count_o), MAX);
    run_check("sat exit", 1, 10, MAX - 1, 0, 1);
    run_check("sat entry", 0, 10, MAX, 1, 1);
    run_check("sat over", 0, 10, MAX, 1, 0);
    mc = MAX;

    // Long hold inside timeout still counts
    p0 = pulse_cnt;
    ph(1, 0, 150); ph(1, 1, 20); ph(0, 1, 20); ph(0, 0, 30);
    check("long hold count", int'(count_o), MAX);
    check("long hold pulses", pulse_cnt - p0, 0);
    run_check("pre-timeout exit", 1, 10, MAX - 1, 0, 1);
    mc = MAX - 1;

    // Timeout in IN1 parks the FSM, rest of entry is ignored
    p0 = pulse_cnt;
    ph(1, 0, 300);
    check("timeout busy", int'(busy_o), 1);
    ph(1, 1, 20); ph(0, 1, 20); ph(0, 0, 30);
    check("timeout count", int'(count_o), mc);
    check("timeout pulses", pulse_cnt - p0, 0);
    check("timeout idle", int'(busy_o), 0);
    ph(1, 0, 300); ph(0, 0, 30);
    check("timeout release count", int'(count_o), mc);
    check("timeout release busy", int'(busy_o), 0);

    // Reset while in IN2
    ph(1, 0, 20); ph(1, 1, 20);
    check("in2 busy", int'(busy_o), 1);
    reset = 1'b1;
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    @(negedge clk);
    check("midreset count", int'(count_o), 0);
    check("midreset busy", int'(busy_o), 0);
    check("midreset ready", int'(ready_o), 0);
    reset = 1'b0;
    ph(0, 0, 20);
    check("post reset ready", int'(ready_o), 1);
    run_check("post reset entry", 0, 20, 1, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
